// File: rtl/sha_w_schedule.sv
// SHA-256 message-schedule generator: passes W[0..15] through, then forms W[16..63]
// from a 16-word sliding window and an external sigma stage, via a one-entry output register.
module sha_w_schedule #(
    parameter int DATA_W    = 32,
    parameter int SIGMA_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] sig_in0,
    output logic [DATA_W-1:0] sig_in1,
    input  logic [DATA_W-1:0] sig_out0,
    input  logic [DATA_W-1:0] sig_out1,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [DATA_W-1:0] w_data,
    output logic [5:0]        w_idx,
    output logic              busy,
    output logic              done
);

    // state | meaning
    // IDLE  | waiting for run
    // LOAD  | accepting message words W[0..15]
    // CALC  | producing W[16..63], one word per SIGMA_LAT+1 cycles
    // DONE  | block finished; done once the output register drains
    typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

    localparam logic [1:0] LAT = 2'(SIGMA_LAT);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] win [16];
    logic [6:0]        t;
    logic [1:0]        cnt, cnt_nxt;
    logic              slot_free, shift, restart;
    logic [DATA_W-1:0] new_word, calc_word;

    assign slot_free = !w_valid || w_ready;
    assign calc_word = sig_out0 + sig_out1 + win[0] + win[9];
    assign sig_in0   = win[1];
    assign sig_in1   = win[14];
    assign busy      = (state == LOAD) || (state == CALC);
    assign done      = (state == DONE) && !w_valid;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        in_ready  = 1'b0;
        shift     = 1'b0;
        restart   = 1'b0;
        new_word  = in_data;
        case (state)
            IDLE, DONE: begin
                if (run) begin
                    restart   = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                in_ready = slot_free;
                if (in_valid && slot_free) begin
                    shift = 1'b1;
                    if (t == 7'd15) begin
                        state_nxt = CALC;
                        cnt_nxt   = 2'd0;
                    end
                end
            end
            CALC: begin
                new_word = calc_word;
                // cnt waits out the sigma pipeline, then holds until the output slot frees
                if (cnt == LAT) begin
                    if (slot_free) begin
                        shift   = 1'b1;
                        cnt_nxt = 2'd0;
                        if (t == 7'd63) state_nxt = DONE;
                    end
                end else begin
                    cnt_nxt = cnt + 2'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            t       <= '0;
            cnt     <= '0;
            w_valid <= 1'b0;
            w_data  <= '0;
            w_idx   <= '0;
            for (int i = 0; i < 16; i++) win[i] <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (restart)    t <= '0;
            else if (shift) t <= t + 7'd1;
            if (shift) begin
                for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                win[15] <= new_word;
                w_data  <= new_word;
                w_idx   <= t[5:0];
                w_valid <= 1'b1;
            end else if (w_ready) begin
                w_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sha_w_schedule.sv
// Bench for sha_w_schedule: three instances (SIGMA_LAT 0, 1, 3) share stimulus, each with a
// behavioural sigma stage; streams are scored against a software SHA-256 schedule model.
module tb_sha_w_schedule;

    localparam int LATS [3] = '{0, 1, 3};

    logic        clk = 1'b0;
    logic        rst, run, in_valid, w_ready;
    logic [31:0] in_data;

    logic        in_ready_a [3];
    logic        w_valid_a  [3];
    logic        busy_a     [3];
    logic        done_a     [3];
    logic [31:0] sig_in0_a  [3];
    logic [31:0] sig_in1_a  [3];
    logic [31:0] sig_out0_a [3];
    logic [31:0] sig_out1_a [3];
    logic [31:0] w_data_a   [3];
    logic [5:0]  w_idx_a    [3];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    bit          mon_en = 1'b0;
    int          nxt  [3];
    int          fa   [3];
    int          la   [3];
    bit          pend [3];
    logic [31:0] exp_w [64];
    logic [31:0] got   [64];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] s0f(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] s1f(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    function automatic void gen_exp(input logic [31:0] blk [16]);
        for (int i = 0; i < 16; i++) exp_w[i] = blk[i];
        for (int i = 16; i < 64; i++)
            exp_w[i] = s1f(exp_w[i-2]) + exp_w[i-7] + s0f(exp_w[i-15]) + exp_w[i-16];
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int LAT = LATS[g];
        logic [31:0] s0c, s1c;
        logic [31:0] p0 [1:3];
        logic [31:0] p1 [1:3];

        assign s0c = s0f(sig_in0_a[g]);
        assign s1c = s1f(sig_in1_a[g]);
        always @(posedge clk) begin
            p0[1] <= s0c;   p1[1] <= s1c;
            p0[2] <= p0[1]; p1[2] <= p1[1];
            p0[3] <= p0[2]; p1[3] <= p1[2];
        end
        if (LAT == 0) begin : g_comb
            assign sig_out0_a[g] = s0c;
            assign sig_out1_a[g] = s1c;
        end else begin : g_pipe
            assign sig_out0_a[g] = p0[LAT];
            assign sig_out1_a[g] = p1[LAT];
        end

        sha_w_schedule #(.DATA_W(32), .SIGMA_LAT(LAT)) dut (
            .clk      (clk),
            .rst      (rst),
            .run      (run),
            .in_valid (in_valid),
            .in_data  (in_data),
            .in_ready (in_ready_a[g]),
            .sig_in0  (sig_in0_a[g]),
            .sig_in1  (sig_in1_a[g]),
            .sig_out0 (sig_out0_a[g]),
            .sig_out1 (sig_out1_a[g]),
            .w_valid  (w_valid_a[g]),
            .w_ready  (w_ready),
            .w_data   (w_data_a[g]),
            .w_idx    (w_idx_a[g]),
            .busy     (busy_a[g]),
            .done     (done_a[g])
        );

        // scoreboard: every accepted word must be the next index with the model's value
        always @(negedge clk) begin
            if (mon_en && rst) begin
                if (pend[g]) begin
                    chk($sformatf("done_after_last_L%0d", LAT), {31'b0, done_a[g]}, 32'd1);
                    pend[g] = 1'b0;
                end
                if (fa[g] < 0 && in_valid && in_ready_a[g]) fa[g] = cyc;
                if (w_valid_a[g] && w_ready) begin
                    chk($sformatf("w_idx_L%0d", LAT), {26'b0, w_idx_a[g]}, nxt[g]);
                    chk($sformatf("w_data%0d_L%0d", nxt[g], LAT), w_data_a[g], exp_w[nxt[g] & 63]);
                    if (g == 1) got[nxt[g] & 63] = w_data_a[g];
                    if (nxt[g] == 63) begin
                        la[g]   = cyc;
                        pend[g] = 1'b1;
                    end
                    nxt[g]++;
                end
            end
        end
    end

    task automatic chk_rst();
        chk("rst_in_ready", {31'b0, in_ready_a[1]}, 32'd0);
        chk("rst_sig_in0",  sig_in0_a[1], 32'd0);
        chk("rst_sig_in1",  sig_in1_a[1], 32'd0);
        chk("rst_w_valid",  {31'b0, w_valid_a[1]}, 32'd0);
        chk("rst_w_data",   w_data_a[1], 32'd0);
        chk("rst_w_idx",    {26'b0, w_idx_a[1]}, 32'd0);
        chk("rst_busy",     {31'b0, busy_a[1]}, 32'd0);
        chk("rst_done",     {31'b0, done_a[1]}, 32'd0);
    endtask

    task automatic load_block(input logic [31:0] blk [16], input bit gaps, input bit run_mid);
        int j = 0;
        int guard = 0;
        bit tog = 1'b1;
        bit acc;
        while (j < 16 && guard < 200) begin
            in_valid = gaps ? tog : 1'b1;
            tog      = !tog;
            in_data  = blk[j];
            run      = run_mid && (j == 5);
            @(negedge clk);
            acc = in_valid && in_ready_a[1];
            @(posedge clk); #1;
            if (acc) j++;
            guard++;
        end
        in_valid = 1'b0;
        run      = 1'b0;
        if (j < 16) chk("load_timeout", j, 32'd16);
    endtask

    task automatic start_block(input logic [31:0] blk [16]);
        gen_exp(blk);
        for (int g = 0; g < 3; g++) begin
            nxt[g] = 0; fa[g] = -1; la[g] = -1; pend[g] = 1'b0;
        end
        mon_en = 1'b1;
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        chk("run_in_ready", {31'b0, in_ready_a[1]}, 32'd1);
        chk("run_busy",     {31'b0, busy_a[1]}, 32'd1);
        chk("run_done_clr", {31'b0, done_a[1]}, 32'd0);
    endtask

    task automatic wait_done();
        int guard = 0;
        while (!(done_a[0] && done_a[1] && done_a[2]) && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("done_all", {31'b0, done_a[0] && done_a[1] && done_a[2]}, 32'd1);
        @(posedge clk); #1;
        for (int g = 0; g < 3; g++) chk($sformatf("word_count_L%0d", LATS[g]), nxt[g], 32'd64);
    endtask

    task automatic wait_idx(input int idx, output bit found);
        int guard = 0;
        found = 1'b0;
        while (!found && guard < 1000) begin
            @(posedge clk); #1;
            found = w_valid_a[1] && (w_idx_a[1] == 6'(idx));
            guard++;
        end
        if (!found) chk("wait_idx_timeout", idx, 32'hFFFFFFFF);
    endtask

    logic [31:0] abc [16];
    logic [31:0] rnd [16];
    bit          found;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; run = 1'b0; in_valid = 1'b0; in_data = '0; w_ready = 1'b1;
        for (int i = 0; i < 16; i++) abc[i] = 32'h0;
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;

        repeat (3) @(posedge clk);
        #1;
        chk_rst();
        rst = 1'b1;
        @(posedge clk); #1;

        // "abc" block, no stalls: stream, hand values, block lengths per latency
        start_block(abc);
        load_block(abc, 1'b0, 1'b0);
        wait_done();
        chk("abc_w16", got[16], 32'h61626380);
        chk("abc_w17", got[17], 32'h000F0000);
        chk("abc_w18", got[18], 32'h7DA86405);
        for (int g = 0; g < 3; g++)
            chk($sformatf("block_len_L%0d", LATS[g]), la[g] - fa[g], 16 + 48 * (LATS[g] + 1));

        // "abc" with LOAD gaps, run pulsed in LOAD and in CALC (run here also restarts from DONE)
        start_block(abc);
        load_block(abc, 1'b1, 1'b1);
        repeat (5) begin @(posedge clk); #1; end
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        chk("calc_run_busy", {31'b0, busy_a[1]}, 32'd1);
        wait_done();

        // random block with backpressure at w_idx 20
        for (int i = 0; i < 16; i++) rnd[i] = $urandom;
        start_block(rnd);
        load_block(rnd, 1'b0, 1'b0);
        wait_idx(20, found);
        w_ready = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            chk("bp_w_data",  w_data_a[1], exp_w[20]);
            chk("bp_w_idx",   {26'b0, w_idx_a[1]}, 32'd20);
            chk("bp_sig_in0", sig_in0_a[1], exp_w[6]);
            chk("bp_sig_in1", sig_in1_a[1], exp_w[19]);
        end
        w_ready = 1'b1;
        wait_done();

        // reset mid-CALC at w_idx 40
        for (int i = 0; i < 16; i++) rnd[i] = $urandom;
        start_block(rnd);
        load_block(rnd, 1'b0, 1'b0);
        wait_idx(40, found);
        mon_en = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk_rst();
        chk("rst_w_valid_L0", {31'b0, w_valid_a[0]}, 32'd0);
        chk("rst_w_valid_L3", {31'b0, w_valid_a[2]}, 32'd0);

        // fresh block after reset
        for (int i = 0; i < 16; i++) rnd[i] = $urandom;
        start_block(rnd);
        load_block(rnd, 1'b0, 1'b0);
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
